// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit.
// Op codes, FSM states and iteration count.
package muldiv_pkg;

    localparam int ITER = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10
    } state_e;

endpackage

// File: rtl/muldiv_unit_cond_neg.sv
// Conditional two's-complement negate.
// Used for operand magnitudes and result sign fix.
module cond_neg #(
    parameter int WIDTH = 32
) (
    input  logic             i_neg,
    input  logic [WIDTH-1:0] i_a,
    output logic [WIDTH-1:0] o_y
);

    // Negate when requested, pass through otherwise
    always_comb begin
        o_y = i_neg ? (~i_a + 1'b1) : i_a;
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit.
// Radix-2 shift-add multiply, restoring divide.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = ITER
) (
    input  logic             clk1,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e r_state;
    state_e w_next;

    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_m;
    logic [CW-1:0]      r_cnt;
    logic               r_is_div;
    logic               r_sa;
    logic               r_sb;
    logic               r_dz;
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_signed;
    logic               w_sa;
    logic               w_sb;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic               w_start;
    logic               w_fix_wr;

    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH:0]     w_trial;
    logic               w_qbit;
    logic [2*WIDTH-1:0] w_div_next;

    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;
    logic [2*WIDTH-1:0] w_prod_fix;

    assign w_signed = ~op[0];
    assign w_sa     = w_signed & a[WIDTH-1];
    assign w_sb     = w_signed & b[WIDTH-1];

    cond_neg #(.WIDTH(WIDTH)) u_mag_a (
        .i_neg (w_sa),
        .i_a   (a),
        .o_y   (w_mag_a)
    );

    cond_neg #(.WIDTH(WIDTH)) u_mag_b (
        .i_neg (w_sb),
        .i_a   (b),
        .o_y   (w_mag_b)
    );

    cond_neg #(.WIDTH(WIDTH)) u_quo_fix (
        .i_neg (r_sa ^ r_sb),
        .i_a   (r_acc[WIDTH-1:0]),
        .o_y   (w_quo_fix)
    );

    cond_neg #(.WIDTH(WIDTH)) u_rem_fix (
        .i_neg (r_sa),
        .i_a   (r_acc[2*WIDTH-1:WIDTH]),
        .o_y   (w_rem_fix)
    );

    cond_neg #(.WIDTH(2*WIDTH)) u_prod_fix (
        .i_neg (r_sa ^ r_sb),
        .i_a   (r_acc),
        .o_y   (w_prod_fix)
    );

    assign w_start  = (r_state == S_IDLE) && start && !flush;
    assign w_fix_wr = (r_state == S_FIX) && !flush;

    // One radix-2 step of multiply and of divide
    always_comb begin
        w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                   + (r_acc[0] ? {1'b0, r_m} : {(WIDTH+1){1'b0}});
        w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};
        w_rem_sh   = r_acc[2*WIDTH-1:WIDTH-1];
        w_trial    = w_rem_sh - {1'b0, r_m};
        w_qbit     = ~w_trial[WIDTH];
        w_div_next = {(w_qbit ? w_trial[WIDTH-1:0] : w_rem_sh[WIDTH-1:0]),
                      r_acc[WIDTH-2:0], w_qbit};
    end

    // State register
    always_ff @(posedge clk1) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; flush aborts CALC and FIX
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start && !flush) begin
                    w_next = S_CALC;
                end
            end
            S_CALC: begin
                if (flush) begin
                    w_next = S_IDLE;
                end else if (r_cnt == LAST) begin
                    w_next = S_FIX;
                end
            end
            S_FIX: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Operand latch and iterative accumulator
    always_ff @(posedge clk1) begin
        if (reset) begin
            r_acc    <= '0;
            r_m      <= '0;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            r_dz     <= 1'b0;
        end else if (w_start) begin
            r_is_div <= op[1];
            r_sa     <= w_sa;
            r_sb     <= w_sb;
            r_dz     <= (b == '0);
            r_cnt    <= '0;
            if (op[1]) begin
                r_m   <= w_mag_b;
                r_acc <= {{WIDTH{1'b0}}, w_mag_a};
            end else begin
                r_m   <= w_mag_a;
                r_acc <= {{WIDTH{1'b0}}, w_mag_b};
            end
        end else if (r_state == S_CALC && !flush) begin
            r_acc <= r_is_div ? w_div_next : w_mul_next;
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // HI/LO: MTHI/MTLO in IDLE, result write in FIX
    always_ff @(posedge clk1) begin
        if (reset) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (r_state == S_IDLE) begin
            if (hi_we) begin
                r_hi <= wdata;
            end
            if (lo_we) begin
                r_lo <= wdata;
            end
        end else if (w_fix_wr) begin
            if (r_is_div) begin
                r_hi <= w_rem_fix;
                r_lo <= r_dz ? {WIDTH{1'b1}} : w_quo_fix;
            end else begin
                r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                r_lo <= w_prod_fix[WIDTH-1:0];
            end
        end
    end

    // Done pulses for the one cycle after the result write
    always_ff @(posedge clk1) begin
        if (reset) begin
            r_done <= 1'b0;
        end else begin
            r_done <= w_fix_wr;
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed testbench for muldiv_unit.
// Hand-computed HI/LO results, latency and flush/reset checks.
module tb_muldiv_unit;

    logic        clk1;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    muldiv_unit dut (
        .clk1  (clk1),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .flush (flush),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    // Launch an op at a negedge and wait (bounded) for done
    task automatic do_op(input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y,
                         output int nbusy, output bit got);
        nbusy = 0;
        got   = 1'b0;
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        @(negedge clk1);
        start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            if (busy) nbusy++;
            @(negedge clk1);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk1);
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctl busy=%b done=%b want 0 0", busy, done);
        end
        checks++;
        if (hi !== 32'h0 || lo !== 32'h0) begin
            errors++;
            $display("FAIL reset_hilo hi=%h lo=%h want 0 0", hi, lo);
        end
    endtask

    task automatic test_multu();
        int  nb;
        bit  got;
        do_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, nb, got);
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL multu_done no done within bound");
        end
        checks++;
        if (nb !== 33) begin
            errors++;
            $display("FAIL multu_busy cycles=%0d want 33", nb);
        end
        checks++;
        if (hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin
            errors++;
            $display("FAIL multu hi=%h lo=%h want fffffffe 00000001",
                     hi, lo);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL multu_idle busy=%b want 0", busy);
        end
        @(negedge clk1);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL multu_pulse done=%b want 0", done);
        end
    endtask

    task automatic test_mult();
        int nb;
        bit got;
        op    = 2'b00;
        a     = 32'hFFFFFFFD;
        b     = 32'd7;
        start = 1'b1;
        hi_we = 1'b1;
        wdata = 32'h12121212;
        @(negedge clk1);
        start = 1'b0;
        hi_we = 1'b0;
        checks++;
        if (hi !== 32'h12121212) begin
            errors++;
            $display("FAIL mthi_with_start hi=%h want 12121212", hi);
        end
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            @(negedge clk1);
        end
        checks++;
        if (!got || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFEB) begin
            errors++;
            $display("FAIL mult_neg got=%b hi=%h lo=%h want ffffffff ffffffeb",
                     got, hi, lo);
        end
        do_op(2'b00, 32'h80000000, 32'h80000000, nb, got);
        checks++;
        if (!got || hi !== 32'h40000000 || lo !== 32'h0) begin
            errors++;
            $display("FAIL mult_min got=%b hi=%h lo=%h want 40000000 0",
                     got, hi, lo);
        end
    endtask

    task automatic test_div();
        int nb;
        bit got;
        do_op(2'b10, 32'hFFFFFFF9, 32'd2, nb, got);
        checks++;
        if (!got || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin
            errors++;
            $display("FAIL div_neg got=%b hi=%h lo=%h want ffffffff fffffffd",
                     got, hi, lo);
        end
        do_op(2'b11, 32'd100, 32'd7, nb, got);
        checks++;
        if (!got || hi !== 32'd2 || lo !== 32'd14) begin
            errors++;
            $display("FAIL divu got=%b hi=%h lo=%h want 2 e", got, hi, lo);
        end
        do_op(2'b10, 32'h80000000, 32'hFFFFFFFF, nb, got);
        checks++;
        if (!got || hi !== 32'h0 || lo !== 32'h80000000) begin
            errors++;
            $display("FAIL div_ovf got=%b hi=%h lo=%h want 0 80000000",
                     got, hi, lo);
        end
    endtask

    task automatic test_divzero();
        int nb;
        bit got;
        do_op(2'b11, 32'h12345678, 32'h0, nb, got);
        checks++;
        if (!got || nb !== 33) begin
            errors++;
            $display("FAIL divu0_lat got=%b cycles=%0d want 1 33", got, nb);
        end
        checks++;
        if (hi !== 32'h12345678 || lo !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL divu0 hi=%h lo=%h want 12345678 ffffffff", hi, lo);
        end
        do_op(2'b10, 32'hFFFFFFF9, 32'h0, nb, got);
        checks++;
        if (!got || hi !== 32'hFFFFFFF9 || lo !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL div0 got=%b hi=%h lo=%h want fffffff9 ffffffff",
                     got, hi, lo);
        end
    endtask

    task automatic test_flush();
        int nb;
        bit got;
        bit seen;
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'hAAAAAAAA;
        @(negedge clk1);
        hi_we = 1'b0;
        lo_we = 1'b0;
        checks++;
        if (hi !== 32'hAAAAAAAA || lo !== 32'hAAAAAAAA) begin
            errors++;
            $display("FAIL mthi_mtlo hi=%h lo=%h want aaaaaaaa", hi, lo);
        end
        op    = 2'b10;
        a     = 32'd1000;
        b     = 32'd3;
        start = 1'b1;
        @(negedge clk1);
        start = 1'b0;
        repeat (9) @(negedge clk1);
        flush = 1'b1;
        @(negedge clk1);
        flush = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL flush_ctl busy=%b done=%b want 0 0", busy, done);
        end
        checks++;
        if (hi !== 32'hAAAAAAAA || lo !== 32'hAAAAAAAA) begin
            errors++;
            $display("FAIL flush_hilo hi=%h lo=%h want aaaaaaaa", hi, lo);
        end
        do_op(2'b11, 32'd100, 32'd7, nb, got);
        checks++;
        if (!got || nb !== 33 || hi !== 32'd2 || lo !== 32'd14) begin
            errors++;
            $display("FAIL after_flush got=%b cyc=%0d hi=%h lo=%h want 1 33 2 e",
                     got, nb, hi, lo);
        end
        // flush together with start in IDLE drops the start
        op    = 2'b01;
        a     = 32'd3;
        b     = 32'd3;
        start = 1'b1;
        flush = 1'b1;
        @(negedge clk1);
        start = 1'b0;
        flush = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (busy || done) seen = 1'b1;
            @(negedge clk1);
        end
        checks++;
        if (seen || hi !== 32'd2 || lo !== 32'd14) begin
            errors++;
            $display("FAIL flush_start act=%b hi=%h lo=%h want 0 2 e",
                     seen, hi, lo);
        end
    endtask

    task automatic test_busy_ignore();
        int nb;
        bit got;
        op    = 2'b01;
        a     = 32'hFFFFFFFF;
        b     = 32'hFFFFFFFF;
        start = 1'b1;
        @(negedge clk1);
        start = 1'b0;
        nb    = 1;
        repeat (3) begin
            @(negedge clk1);
            nb++;
        end
        op    = 2'b11;
        a     = 32'd5;
        b     = 32'd1;
        start = 1'b1;
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'h55555555;
        @(negedge clk1);
        nb++;
        start = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        checks++;
        if (hi !== 32'd2 || lo !== 32'd14) begin
            errors++;
            $display("FAIL we_busy hi=%h lo=%h want 2 e", hi, lo);
        end
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            if (busy) nb++;
            @(negedge clk1);
        end
        checks++;
        if (!got || nb !== 34 || hi !== 32'hFFFFFFFE || lo !== 32'h1) begin
            errors++;
            $display("FAIL start_busy got=%b cyc=%0d hi=%h lo=%h want 1 34 fffffffe 1",
                     got, nb, hi, lo);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        op    = 2'b00;
        a     = 32'd3;
        b     = 32'd5;
        start = 1'b1;
        @(negedge clk1);
        start = 1'b0;
        repeat (14) @(negedge clk1);
        reset = 1'b1;
        @(negedge clk1);
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid busy=%b done=%b hi=%h lo=%h want 0 0 0 0",
                     busy, done, hi, lo);
        end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (busy || done || hi !== 32'h0) seen = 1'b1;
            @(negedge clk1);
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL reset_quiet activity after reset act=1 want 0");
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        flush = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        wdata = '0;
        @(negedge clk1);
        test_reset();
        test_multu();
        test_mult();
        test_div();
        test_divzero();
        test_flush();
        test_busy_ignore();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
